// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the data-memory access controller.
// State codes, access size codes and the alignment rule.
package mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b10;
    localparam logic [1:0] SIZE_BYTE = 2'b11;

    function automatic logic is_misaligned(
        input logic [1:0] size,
        input logic [1:0] addr_lo
    );
        logic mis;
        case (size)
            SIZE_HALF: mis = addr_lo[0];
            SIZE_BYTE: mis = 1'b0;
            default:   mis = |addr_lo;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_lane.sv
// Byte/half lane extraction for loads and lane merge for
// read-modify-write stores.
import mem_access_ctrl_pkg::*;

module mem_lane_unit (
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [31:0] shifted;
    logic [15:0] half_val;
    logic [7:0]  byte_val;
    logic [4:0]  lane_base;

    assign lane_base = {addr_lo, 3'b000};
    assign shifted   = rdata >> lane_base;
    assign byte_val  = shifted[7:0];
    assign half_val  = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        load_data  = rdata;
        merge_data = rdata;
        case (size)
            SIZE_BYTE: begin
                load_data = {{24{sign & byte_val[7]}}, byte_val};
                merge_data[lane_base +: 8] = wdata[7:0];
            end
            SIZE_HALF: begin
                load_data = {{16{sign & half_val[15]}}, half_val};
                if (addr_lo[1])
                    merge_data[31:16] = wdata;
                else
                    merge_data[15:0] = wdata;
            end
            default: begin
                load_data  = rdata;
                merge_data = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// One-at-a-time load/store controller toward a variable-latency
// single-port word memory, with RMW for sub-word stores.
import mem_access_ctrl_pkg::*;

module mem_access_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_sign,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);

    localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    state_e           state, state_next;
    logic             write_q, sign_q;
    logic [1:0]       size_q, addr_lo_q;
    logic [15:0]      wdata_q;
    logic [31:0]      rdata_q;
    logic             err_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             accept, mis, timeout, busy;
    logic [31:0]      load_data, merge_data;

    assign req_ready  = (state == IDLE) && !rst;
    assign accept     = (state == IDLE) && req_valid;
    assign mis        = is_misaligned(req_size, req_addr[1:0]);
    assign busy       = (state == READ) || (state == WRITE);
    assign timeout    = busy && !mem_ready && (wait_cnt == CNT_LAST);
    assign resp_valid = (state == RESP);
    assign resp_err   = resp_valid & err_q;
    assign resp_rdata = resp_valid ? rdata_q : 32'd0;

    mem_lane_unit u_lane (
        .size       (size_q),
        .sign       (sign_q),
        .addr_lo    (addr_lo_q),
        .rdata      (mem_rdata),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (mis)
                        state_next = RESP;
                    else if (req_write && (req_size != SIZE_HALF)
                             && (req_size != SIZE_BYTE))
                        state_next = WRITE;
                    else
                        state_next = READ;
                end
            end
            READ: begin
                if (mem_ready)
                    state_next = write_q ? WRITE : RESP;
                else if (timeout)
                    state_next = RESP;
            end
            WRITE: begin
                if (mem_ready || timeout)
                    state_next = RESP;
            end
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_q   <= 1'b0;
            sign_q    <= 1'b0;
            size_q    <= SIZE_WORD;
            addr_lo_q <= 2'b00;
            wdata_q   <= 16'd0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
            wait_cnt  <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
        end else begin
            mem_en <= (state_next == READ) || (state_next == WRITE);
            mem_we <= (state_next == WRITE);

            // Counter restarts whenever a new access phase begins.
            if (state_next != state)
                wait_cnt <= '0;
            else if (busy && !mem_ready)
                wait_cnt <= wait_cnt + 1'b1;

            if (accept) begin
                write_q   <= req_write;
                sign_q    <= req_sign;
                size_q    <= req_size;
                addr_lo_q <= req_addr[1:0];
                wdata_q   <= req_wdata[15:0];
                rdata_q   <= 32'd0;
                err_q     <= mis;
                if (!mis) begin
                    mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                    mem_wdata <= req_wdata;
                end
            end

            if (state == READ && mem_ready) begin
                if (write_q)
                    mem_wdata <= merge_data;
                else
                    rdata_q <= load_data;
            end

            if (timeout)
                err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a scripted-latency
// memory responder.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_sign;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_en, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(32), .MAX_WAIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_sign   (req_sign),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(
        input  logic        w,
        input  logic [1:0]  sz,
        input  logic        sg,
        input  logic [31:0] a,
        input  logic [31:0] wd,
        input  logic [31:0] rw,
        input  int          waits,
        output int          lat,
        output logic [31:0] rd,
        output logic        er,
        output logic [31:0] maddr,
        output logic [31:0] mwd,
        output logic        en_seen,
        output logic        we_seen
    );
        int cnt;
        cnt = 0; lat = 0; rd = 32'hx; er = 1'bx;
        maddr = 32'd0; mwd = 32'd0;
        en_seen = 1'b0; we_seen = 1'b0;
        req_valid = 1'b1; req_write = w; req_size = sz;
        req_sign = sg; req_addr = a; req_wdata = wd;
        tick();
        req_valid = 1'b0;
        req_addr  = 32'hxxxx_xxxx;
        for (int c = 1; c < 40; c++) begin
            if (resp_valid) begin
                lat = c; rd = resp_rdata; er = resp_err;
                break;
            end
            if (mem_en) begin
                en_seen = 1'b1;
                maddr = mem_addr;
                if (mem_we) begin
                    we_seen = 1'b1;
                    mwd = mem_wdata;
                end
                if (cnt == waits) begin
                    mem_ready = 1'b1;
                    mem_rdata = rw;
                    cnt = 0;
                end else begin
                    mem_ready = 1'b0;
                    cnt++;
                end
            end else begin
                mem_ready = 1'b0;
            end
            tick();
        end
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        tick();
    endtask

    int          lat;
    logic [31:0] rd, maddr, mwd;
    logic        er, en_seen, we_seen;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_size = 2'b00; req_sign = 1'b0; req_addr = 32'h0;
        req_wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
        tick(); tick();
        check("rst_req_ready",  {31'd0, req_ready},  32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_err",   {31'd0, resp_err},   32'd0);
        check("rst_resp_rdata", resp_rdata,          32'd0);
        check("rst_mem_en",     {31'd0, mem_en},     32'd0);
        check("rst_mem_we",     {31'd0, mem_we},     32'd0);
        check("rst_mem_addr",   mem_addr,            32'd0);
        check("rst_mem_wdata",  mem_wdata,           32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);

        // lb 0x103 sign-extended, zero wait
        do_req(1'b0, 2'b11, 1'b1, 32'h103, 32'h0, 32'h80FF_1234, 0,
               lat, rd, er, maddr, mwd, en_seen, we_seen);
        check("lb_lat",   lat,   2);
        check("lb_addr",  maddr, 32'h100);
        check("lb_rdata", rd,    32'hFFFF_FF80);
        check("lb_err",   {31'd0, er}, 32'd0);
        check("lb_pulse", {31'd0, resp_valid}, 32'd0);
        check("lb_ready", {31'd0, req_ready},  32'd1);

        // lhu 0x22, three wait cycles
        do_req(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 32'hBEEF_0001, 3,
               lat, rd, er, maddr, mwd, en_seen, we_seen);
        check("lhu_lat",   lat, 5);
        check("lhu_rdata", rd,  32'h0000_BEEF);
        check("lhu_addr",  maddr, 32'h20);

        // lh 0x06 sign-extended upper half
        do_req(1'b0, 2'b10, 1'b1, 32'h06, 32'h0, 32'h8001_0000, 0,
               lat, rd, er, maddr, mwd, en_seen, we_seen);
        check("lh_rdata", rd, 32'hFFFF_8001);

        // lbu 0x100 zero-extended lane 0
        do_req(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'h80FF_12F4, 1,
               lat, rd, er, maddr, mwd, en_seen, we_seen);
        check("lbu_rdata", rd,  32'h0000_00F4);
        check("lbu_lat",   lat, 3);

        // lw passes word unchanged
        do_req(1'b0, 2'b00, 1'b1, 32'h84, 32'h0, 32'h89AB_CDEF, 0,
               lat, rd, er, maddr, mwd, en_seen, we_seen);
        check("lw_rdata", rd, 32'h89AB_CDEF);

        // sb 0x41 read-modify-write
        do_req(1'b1, 2'b11, 1'b0, 32'h41, 32'h0000_00AB, 32'h1122_3344,
               0, lat, rd, er, maddr, mwd, en_seen, we_seen);
        check("sb_lat",   lat, 3);
        check("sb_wdata", mwd, 32'h1122_AB44);
        check("sb_we",    {31'd0, we_seen}, 32'd1);
        check("sb_err",   {31'd0, er}, 32'd0);
        check("sb_rdata", rd, 32'd0);

        // sh 0x12 merges upper half
        do_req(1'b1, 2'b10, 1'b0, 32'h12, 32'hFFFF_5A5A, 32'h1122_3344,
               0, lat, rd, er, maddr, mwd, en_seen, we_seen);
        check("sh_wdata", mwd,   32'h5A5A_3344);
        check("sh_addr",  maddr, 32'h10);

        // sw word store, one wait
        do_req(1'b1, 2'b00, 1'b0, 32'h80, 32'hDEAD_BEEF, 32'h0, 1,
               lat, rd, er, maddr, mwd, en_seen, we_seen);
        check("sw_lat",   lat, 3);
        check("sw_wdata", mwd, 32'hDEAD_BEEF);

        // misaligned sw 0x42 and lh 0x43
        do_req(1'b1, 2'b00, 1'b0, 32'h42, 32'h1, 32'h0, 0,
               lat, rd, er, maddr, mwd, en_seen, we_seen);
        check("mis_sw_lat", lat, 1);
        check("mis_sw_err", {31'd0, er}, 32'd1);
        check("mis_sw_en",  {31'd0, en_seen}, 32'd0);
        do_req(1'b0, 2'b10, 1'b1, 32'h43, 32'h0, 32'h0, 0,
               lat, rd, er, maddr, mwd, en_seen, we_seen);
        check("mis_lh_lat", lat, 1);
        check("mis_lh_err", {31'd0, er}, 32'd1);
        check("mis_lh_en",  {31'd0, en_seen}, 32'd0);
        check("mis_lh_rd",  rd, 32'd0);

        // timeout on load and on RMW read phase
        do_req(1'b0, 2'b00, 1'b0, 32'h200, 32'h0, 32'h1234, 100,
               lat, rd, er, maddr, mwd, en_seen, we_seen);
        check("to_lw_lat", lat, 5);
        check("to_lw_err", {31'd0, er}, 32'd1);
        check("to_lw_rd",  rd, 32'd0);
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h7777, 32'h0, 100,
               lat, rd, er, maddr, mwd, en_seen, we_seen);
        check("to_sh_lat", lat, 5);
        check("to_sh_err", {31'd0, er}, 32'd1);
        check("to_sh_we",  {31'd0, we_seen}, 32'd0);

        // reset while in the write phase of an RMW
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b11;
        req_addr = 32'h41; req_wdata = 32'hCD;
        tick();
        req_valid = 1'b0;
        mem_ready = 1'b1; mem_rdata = 32'h0;
        tick();
        mem_ready = 1'b0;
        check("rmw_in_write", {30'd0, mem_en, mem_we}, 32'd3);
        rst = 1'b1;
        tick();
        check("rmw_rst_en",   {31'd0, mem_en},     32'd0);
        check("rmw_rst_resp", {31'd0, resp_valid}, 32'd0);
        rst = 1'b0;
        tick();
        check("rmw_rst_ready", {31'd0, req_ready},  32'd1);
        check("rmw_rst_resp2", {31'd0, resp_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Multi-cycle data-memory access controller between the CPU's MEM stage and a single-port, word-wide data memory with variable latency. It accepts one load/store request at a time, enforces alignment, and performs read-modify-write for byte/halfword stores. It also returns sign- or zero-extended load data using the same size/sign encoding as the load-extraction path.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width.
- `MAX_WAIT`, 255, memory wait-cycle limit before timeout error.

Ports:
- `clk` in 1: the single clock; all logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: CPU request present.
- `req_ready` out 1: controller can accept; high only in IDLE.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 2'b10 half, 2'b11 byte, other = word.
- `req_sign` in 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: misaligned or timeout; qualified by `resp_valid`.
- `mem_en` out 1: memory access request.
- `mem_we` out 1: write strobe.
- `mem_addr` out ADDR_W: word address, {req_addr[ADDR_W-1:2], 2'b00}.
- `mem_wdata` out 32: full word to write.
- `mem_rdata` in 32: read word, valid when `mem_ready` is high.
- `mem_ready` in 1: memory completes the current access this cycle.

## Operation
- **States:** IDLE, READ, WRITE, RESP.
- **IDLE:** accept when `req_valid && req_ready`; latch the request fields.
  - Misaligned → RESP with err=1 and no memory access. Misaligned means half with addr[0]=1, or word with addr[1:0]≠0.
  - Load → READ.
  - Word store → WRITE.
  - Byte/half store → READ (RMW).
- **READ:** `mem_en`=1, `mem_we`=0, `mem_addr` held stable.
  - On `mem_ready`, capture `mem_rdata`.
  - Load → RESP with extracted data.
  - Sub-word store → WRITE with the merged word.
- **WRITE:** `mem_en`=1, `mem_we`=1, `mem_wdata` held stable.
  - On `mem_ready` → RESP.
- **Merge:**
  - Byte: lane addr[1:0] is replaced by wdata[7:0].
  - Half: lane addr[1] is replaced by wdata[15:0] (bits 15:0 if addr[1]=0, else 31:16).
  - All other bits keep the read value.
- **Extraction:**
  - Half: lane addr[1].
  - Byte: lane addr[1:0].
  - Extended to 32 bits per `req_sign`.
  - Word: passed unchanged.
- **Timeout:** a wait counter clears on entering READ/WRITE and increments each cycle without `mem_ready`.
  - When it reaches `MAX_WAIT` → RESP with err=1.
  - An aborted RMW performs no write.
- **RESP:** `resp_valid`=1 for exactly one cycle, then IDLE. There is no response backpressure.

## Timing
- **Reset values:** `req_ready`=0 during reset, 1 from the first cycle after reset. `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- **Latency:** accept at cycle T; memory access starts at T+1. With zero-wait memory (`mem_ready` in the first cycle):
  - Load / word store: `resp_valid` at T+2.
  - Sub-word store: `resp_valid` at T+3.
  - Misaligned: `resp_valid` at T+1.
- Each memory wait cycle adds one cycle.
- **Throughput:** the next request is accepted no earlier than the cycle after RESP.
- `mem_en`, `mem_we`, `mem_addr` and `mem_wdata` are registered and stable from assertion until the `mem_ready` cycle inclusive. `mem_en` drops the cycle after `mem_ready`, except READ→WRITE, where `mem_en` stays high and `mem_we` rises.
- `mem_ready` outside READ/WRITE is ignored.
- **Reset mid-operation:** state → IDLE at that edge; the pending request is discarded; no `resp_valid`; `mem_en`=0 the next cycle.
- Request inputs are don't-care except in IDLE.

## Structure
- **Shared package:** state encoding (IDLE=2'd0, READ=2'd1, WRITE=2'd2, RESP=2'd3) and size codes SIZE_HALF=2'b10, SIZE_BYTE=2'b11, SIZE_WORD=2'b00.
- **Sub-module:** the combinational lane extractor/merger `mem_lane_unit` (extract + merge), instantiated once.
- The FSM, request latch and wait counter live in `mem_access_ctrl`.

## Test plan
- **Sign-extended byte load:** lb addr 0x103, mem_rdata 0x80FF_1234, zero wait → mem_addr 0x100, resp_rdata 0xFFFF_FF80, resp_valid at T+2.
- **Zero-extended half load:** lhu addr 0x22, mem_rdata 0xBEEF_0001, mem_ready after 3 waits → resp_rdata 0x0000_BEEF, resp_valid at T+5.
- **Byte RMW store:** sb addr 0x41, wdata 0x0000_00AB, read returns 0x1122_3344 → WRITE with mem_wdata 0x1122_AB44, then one resp_valid with err=0.
- **Misaligned requests:** sw 0x42 and lh 0x43 → resp_err=1 at T+1, mem_en never asserted.
- **Timeout:** MAX_WAIT=4, mem_ready held low → resp_err=1 after 4 wait cycles, mem_we never high.
- **Reset mid-RMW:** rst asserted in WRITE → mem_en=0 the next cycle, no resp_valid, req_ready=1 after rst deasserts.
